// File: rtl/axicb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axicb_pkg
// Description : Shared constants and helpers for the crossbar grant tracker.
// Revision    : 1.0 - initial release
// ============================================================================
package axicb_pkg;

    localparam int ONEHOT_MAX_W = 16;

    // Counter width able to represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Index of the lowest set bit; 0 for an all-zero vector.
    function automatic int onehot_to_idx(input logic [ONEHOT_MAX_W-1:0] vec);
        int idx;
        idx = 0;
        for (int i = ONEHOT_MAX_W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axicb_scfifo.sv
`default_nettype none
// ============================================================================
// Module      : axicb_scfifo
// Description : Generic synchronous FIFO with wrap-bit pointers and occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module axicb_scfifo
    import axicb_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      srst,
    input  logic                      i_push,
    input  logic                      i_pop,
    input  logic [WIDTH-1:0]          i_wdata,
    output logic [WIDTH-1:0]          o_rdata,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [cnt_w(DEPTH)-1:0]   o_count
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = cnt_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_rd_ptr;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    // Same slot index with opposite wrap bits means the writer lapped the reader.
    assign w_full  = (r_wr_ptr[CNT_W-1] != r_rd_ptr[CNT_W-1]) &&
                     (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    assign w_do_push = i_push & ~w_full;
    assign w_do_pop  = i_pop & ~w_empty;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rd_ptr[ADDR_W-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_wr_ptr - r_rd_ptr;

endmodule
`default_nettype wire

// File: rtl/axicb_grant_tracker.sv
`default_nettype none
// ============================================================================
// Module      : axicb_grant_tracker
// Description : Records arbiter grants in order and steers responses back.
// Revision    : 1.0 - initial release
// ============================================================================
module axicb_grant_tracker
    import axicb_pkg::*;
#(
    parameter int REQ_NB = 4,
    parameter int DEPTH  = 8
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      srst,
    input  logic [REQ_NB-1:0]         req_grant,
    input  logic                      req_push,
    output logic                      req_ready,
    input  logic                      rsp_valid,
    input  logic                      rsp_last,
    output logic                      rsp_ready,
    output logic [REQ_NB-1:0]         rsp_valid_o,
    input  logic [REQ_NB-1:0]         rsp_ready_i,
    output logic [REQ_NB-1:0]         rsp_sel,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    logic [REQ_NB-1:0] w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    assign req_ready = ~w_full;
    assign w_push    = req_push & req_ready & (|req_grant);

    axicb_scfifo #(
        .WIDTH (REQ_NB),
        .DEPTH (DEPTH)
    ) u_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .srst    (srst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (req_grant),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count)
    );

    // Storage is not reset, so the head must be masked while empty.
    assign rsp_sel     = w_empty ? '0 : w_head;
    assign rsp_valid_o = rsp_sel & {REQ_NB{rsp_valid}};
    assign rsp_ready   = |(rsp_sel & rsp_ready_i);
    assign w_pop       = rsp_valid & rsp_ready & rsp_last;

    a_grant_onehot: assert property (@(posedge aclk) disable iff (!aresetn || srst)
        req_push |-> $onehot0(req_grant));

    a_no_push_full: assert property (@(posedge aclk) disable iff (!aresetn || srst)
        w_full |-> !w_push);

    a_sel_onehot: assert property (@(posedge aclk) disable iff (!aresetn || srst)
        (rsp_sel == '0) ||
        (ONEHOT_MAX_W'(rsp_sel) == (ONEHOT_MAX_W'(1) << onehot_to_idx(ONEHOT_MAX_W'(rsp_sel)))));

endmodule
`default_nettype wire

// File: tb/tb_axicb_grant_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_axicb_grant_tracker
// Description : Directed scoreboard bench for the response grant tracker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axicb_grant_tracker;

    localparam int REQ_NB = 4;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              aclk;
    logic              aresetn;
    logic              srst;
    logic [REQ_NB-1:0] req_grant;
    logic              req_push;
    logic              req_ready;
    logic              rsp_valid;
    logic              rsp_last;
    logic              rsp_ready;
    logic [REQ_NB-1:0] rsp_valid_o;
    logic [REQ_NB-1:0] rsp_ready_i;
    logic [REQ_NB-1:0] rsp_sel;
    logic [CNT_W-1:0]  count;

    int n_checks = 0;
    int n_errors = 0;

    logic [REQ_NB-1:0] expq [$];
    logic [REQ_NB-1:0] mon_exp;

    axicb_grant_tracker #(
        .REQ_NB (REQ_NB),
        .DEPTH  (DEPTH)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .srst        (srst),
        .req_grant   (req_grant),
        .req_push    (req_push),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_last    (rsp_last),
        .rsp_ready   (rsp_ready),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_sel     (rsp_sel),
        .count       (count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every transferred beat must land on the next expected requester.
    always @(negedge aclk) begin
        if (aresetn && !srst && rsp_valid && rsp_ready) begin
            if (expq.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL beat_unexpected: got rsp_valid_o=%0h, expected no transfer", rsp_valid_o);
            end else begin
                mon_exp = expq.pop_front();
                check("beat_route", 32'(rsp_valid_o), 32'(mon_exp));
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic push(input logic [REQ_NB-1:0] g);
        req_push  = 1'b1;
        req_grant = g;
        tick();
        req_push  = 1'b0;
        req_grant = '0;
    endtask

    task automatic beat(input logic [REQ_NB-1:0] e, input logic last);
        rsp_valid = 1'b1;
        rsp_last  = last;
        expq.push_back(e);
        tick();
    endtask

    task automatic idle();
        rsp_valid = 1'b0;
        rsp_last  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        aresetn     = 1'b0;
        srst        = 1'b0;
        req_grant   = '0;
        req_push    = 1'b0;
        rsp_valid   = 1'b0;
        rsp_last    = 1'b0;
        rsp_ready_i = '1;
        tick();
        tick();
        aresetn = 1'b1;
        #1;
        check("rst_count", 32'(count), 0);
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_rsp_ready", 32'(rsp_ready), 0);
        check("rst_rsp_sel", 32'(rsp_sel), 0);
        check("rst_valid_o", 32'(rsp_valid_o), 0);

        // In-order routing of single-beat responses
        push(4'b0001);
        push(4'b0100);
        push(4'b0010);
        check("t1_count3", 32'(count), 3);
        check("t1_head", 32'(rsp_sel), 32'h1);
        beat(4'b0001, 1'b1);
        check("t1_count2", 32'(count), 2);
        beat(4'b0100, 1'b1);
        beat(4'b0010, 1'b1);
        idle();
        #1;
        check("t1_count0", 32'(count), 0);

        // Burst held on one requester until last
        push(4'b0010);
        beat(4'b0010, 1'b0);
        beat(4'b0010, 1'b0);
        beat(4'b0010, 1'b0);
        check("t2_hold_count", 32'(count), 1);
        check("t2_hold_sel", 32'(rsp_sel), 32'h2);
        beat(4'b0010, 1'b1);
        idle();
        #1;
        check("t2_count0", 32'(count), 0);

        // Fill, overflow attempt, pop with blocked push, wrap
        push(4'b0001); push(4'b0010); push(4'b0100); push(4'b1000);
        push(4'b0001); push(4'b0010); push(4'b0100); push(4'b1000);
        check("t3_full_count", 32'(count), 8);
        check("t3_full_ready", 32'(req_ready), 0);
        push(4'b0001);
        check("t3_ignored_push", 32'(count), 8);
        req_push  = 1'b1;
        req_grant = 4'b1000;
        beat(4'b0001, 1'b1);
        req_push  = 1'b0;
        req_grant = '0;
        idle();
        #1;
        check("t3_pop_count", 32'(count), 7);
        check("t3_pop_ready", 32'(req_ready), 1);
        push(4'b1000);
        check("t3_wrap_count", 32'(count), 8);
        beat(4'b0010, 1'b1); beat(4'b0100, 1'b1); beat(4'b1000, 1'b1); beat(4'b0001, 1'b1);
        beat(4'b0010, 1'b1); beat(4'b0100, 1'b1); beat(4'b1000, 1'b1); beat(4'b1000, 1'b1);
        idle();
        #1;
        check("t3_drained", 32'(count), 0);

        // No bypass when the first push meets a waiting response
        req_push  = 1'b1;
        req_grant = 4'b1000;
        rsp_valid = 1'b1;
        rsp_last  = 1'b1;
        #1;
        check("t4_no_bypass_ready", 32'(rsp_ready), 0);
        check("t4_no_bypass_valid", 32'(rsp_valid_o), 0);
        expq.push_back(4'b1000);
        tick();
        req_push  = 1'b0;
        req_grant = '0;
        #1;
        check("t4_next_valid", 32'(rsp_valid_o), 32'h8);
        tick();
        idle();
        #1;
        check("t4_count0", 32'(count), 0);

        // Granted requester back-pressure
        push(4'b0100);
        rsp_ready_i = 4'b1011;
        rsp_valid   = 1'b1;
        rsp_last    = 1'b1;
        #1;
        check("t5_stall_ready", 32'(rsp_ready), 0);
        check("t5_stall_valid", 32'(rsp_valid_o), 32'h4);
        tick();
        check("t5_stall_count", 32'(count), 1);
        rsp_ready_i = 4'b1111;
        beat(4'b0100, 1'b1);
        idle();
        #1;
        check("t5_release_count", 32'(count), 0);

        // Synchronous reset mid-burst
        push(4'b0001); push(4'b0010); push(4'b0100);
        beat(4'b0001, 1'b0);
        idle();
        srst = 1'b1;
        tick();
        srst = 1'b0;
        #1;
        check("t6_srst_count", 32'(count), 0);
        check("t6_srst_sel", 32'(rsp_sel), 0);
        check("t6_srst_ready", 32'(req_ready), 1);
        check("t6_srst_rsp_ready", 32'(rsp_ready), 0);

        // Asynchronous reset mid-burst
        push(4'b0001); push(4'b0010); push(4'b0100);
        beat(4'b0001, 1'b0);
        idle();
        #1;
        aresetn = 1'b0;
        #1;
        check("t6_arst_count", 32'(count), 0);
        check("t6_arst_sel", 32'(rsp_sel), 0);
        check("t6_arst_ready", 32'(req_ready), 1);
        tick();
        aresetn = 1'b1;
        #1;
        check("t6_arst_post_count", 32'(count), 0);

        // Recovery after reset
        push(4'b0100);
        check("t7_recover_sel", 32'(rsp_sel), 32'h4);
        beat(4'b0100, 1'b1);
        idle();
        tick();
        check("t7_recover_count", 32'(count), 0);
        check("scoreboard_empty", 32'(expq.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
